ysyx_23060111_lsu: RTL

Load/store unit directly downstream of the execute stage. It accepts one memory request per transaction: effective address, store data, access size and sign flag. It drives a handshaked, variable-latency word-wide data bus, with lane shifting and byte strobes for stores and extraction plus sign/zero extension for loads. It returns load data, or a store completion, to writeback through a valid/ready handshake, and reports misalignment and bus timeout as errors.

---
 rtl/ysyx_23060111_pkg.sv | 33 +++
 rtl/ysyx_23060111_lsu_align.sv | 36 +++
 rtl/ysyx_23060111_lsu.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060111_pkg.sv
// Shared encodings and helpers for the ysyx_23060111 load/store unit.
package ysyx_23060111_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  function automatic logic [3:0] gen_strb(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    return 4'b0001 << off;
      SZ_H:    return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  // Size 3 is reserved and always rejected.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      SZ_W:    return off != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_23060111_lsu_align.sv
// Byte-lane steering: store strobes/replication and load lane extraction with extension.
module ysyx_23060111_lsu_align
  import ysyx_23060111_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext
);

  logic [31:0] lane;

  always_comb begin
    lane  = rdata >> {off, 3'b000};
    wstrb = gen_strb(size, off);
    case (size)
      SZ_B: begin
        wdata_sh  = {4{wdata[7:0]}};
        rdata_ext = is_unsigned ? {24'd0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
      end
      SZ_H: begin
        wdata_sh  = {2{wdata[15:0]}};
        rdata_ext = is_unsigned ? {16'd0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      end
      default: begin
        wdata_sh  = wdata;
        rdata_ext = rdata;
      end
    endcase
  end

endmodule

// File: rtl/ysyx_23060111_lsu.sv
// Load/store unit: one outstanding request on a handshaked, variable-latency word bus.
module ysyx_23060111_lsu
  import ysyx_23060111_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned CNT_W = 32;

  state_t            state, state_n;
  logic [1:0]        off_q, off_n, size_q, size_n;
  logic              uns_q, uns_n, wen_q, wen_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              req_ready_n, resp_valid_n, resp_err_n, mem_valid_n, mem_wen_n;
  logic [31:0]       resp_rdata_n, mem_wdata_n;
  logic [3:0]        mem_wstrb_n;
  logic [ADDR_W-1:0] mem_addr_n;

  logic [1:0]        off_sel_c, size_sel_c;
  logic [3:0]        strb_c;
  logic [31:0]       wdata_sh_c, rdata_ext_c;

  // Store lanes come from the live request at accept; load lanes from the captured one.
  assign off_sel_c  = (state == ST_IDLE) ? req_addr[1:0] : off_q;
  assign size_sel_c = (state == ST_IDLE) ? req_size : size_q;

  ysyx_23060111_lsu_align u_align (
    .off         (off_sel_c),
    .size        (size_sel_c),
    .is_unsigned (uns_q),
    .wdata       (req_wdata),
    .rdata       (mem_rdata),
    .wstrb       (strb_c),
    .wdata_sh    (wdata_sh_c),
    .rdata_ext   (rdata_ext_c)
  );

  always_comb begin
    state_n      = state;
    off_n        = off_q;
    size_n       = size_q;
    uns_n        = uns_q;
    wen_n        = wen_q;
    cnt_n        = cnt;
    resp_valid_n = resp_valid;
    resp_rdata_n = resp_rdata;
    resp_err_n   = resp_err;
    mem_valid_n  = mem_valid;
    mem_addr_n   = mem_addr;
    mem_wen_n    = mem_wen;
    mem_wdata_n  = mem_wdata;
    mem_wstrb_n  = mem_wstrb;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          off_n  = req_addr[1:0];
          size_n = req_size;
          uns_n  = req_unsigned;
          wen_n  = req_wen;
          if (is_misaligned(req_size, req_addr[1:0])) begin
            state_n      = ST_RESP;
            resp_valid_n = 1'b1;
            resp_err_n   = 1'b1;
            resp_rdata_n = 32'd0;
          end else begin
            state_n     = ST_REQ;
            mem_valid_n = 1'b1;
            mem_addr_n  = {req_addr[ADDR_W-1:2], 2'b00};
            mem_wen_n   = req_wen;
            mem_wdata_n = req_wen ? wdata_sh_c : 32'd0;
            mem_wstrb_n = req_wen ? strb_c : 4'b0000;
          end
        end
      end
      ST_REQ: begin
        if (mem_ready) begin
          state_n     = ST_WAIT;
          mem_valid_n = 1'b0;
          cnt_n       = '0;
        end
      end
      ST_WAIT: begin
        // A response arriving on the timeout cycle still completes normally.
        if (mem_rvalid) begin
          state_n      = ST_RESP;
          resp_valid_n = 1'b1;
          resp_err_n   = 1'b0;
          resp_rdata_n = wen_q ? 32'd0 : rdata_ext_c;
        end else if (TIMEOUT != 0 && cnt == CNT_W'(TIMEOUT - 1)) begin
          state_n      = ST_RESP;
          resp_valid_n = 1'b1;
          resp_err_n   = 1'b1;
          resp_rdata_n = 32'd0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_n      = ST_IDLE;
          resp_valid_n = 1'b0;
          resp_err_n   = 1'b0;
          resp_rdata_n = 32'd0;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    req_ready_n = (state_n == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      off_q      <= 2'd0;
      size_q     <= 2'd0;
      uns_q      <= 1'b0;
      wen_q      <= 1'b0;
      cnt        <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
      mem_valid  <= 1'b0;
      mem_addr   <= '0;
      mem_wen    <= 1'b0;
      mem_wdata  <= 32'd0;
      mem_wstrb  <= 4'd0;
    end else begin
      state      <= state_n;
      off_q      <= off_n;
      size_q     <= size_n;
      uns_q      <= uns_n;
      wen_q      <= wen_n;
      cnt        <= cnt_n;
      req_ready  <= req_ready_n;
      resp_valid <= resp_valid_n;
      resp_rdata <= resp_rdata_n;
      resp_err   <= resp_err_n;
      mem_valid  <= mem_valid_n;
      mem_addr   <= mem_addr_n;
      mem_wen    <= mem_wen_n;
      mem_wdata  <= mem_wdata_n;
      mem_wstrb  <= mem_wstrb_n;
    end
  end

endmodule
